// File: rtl/dft_pkg.sv
// dft_pkg: shared scan FSM encoding and default widths for the scan load and capture sides.
package dft_pkg;
  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load shift register emitting bit 0 first.
module piso_shreg #(
  parameter int W = dft_pkg::WORD_W_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] d,
  output logic         so
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (clr) r_q <= '0;
    else if (ld) r_q <= d;
    else if (sh) r_q <= {1'b0, r_q[W-1:1]};
  end
  assign so = r_q[0];
endmodule

// File: rtl/dft_scan_driver.sv
// dft_scan_driver: streams parallel words into a scan chain LSB first, len bits per operation.
module dft_scan_driver
  import dft_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [WORD_W-1:0] din,
  input  logic              din_val,
  output logic              din_rdy,
  output logic              dft_sout,
  output logic              sc_sen,
  output logic              busy,
  output logic              done
);
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  state_t            r_state, w_nxt;
  logic [CNT_W-1:0]  r_rem;
  logic [BW-1:0]     r_bcnt;
  logic              r_din_rdy, r_sc_sen, r_busy, r_done;
  logic              w_xfer, w_shift, w_sout;
  assign w_xfer  = r_din_rdy & din_val;
  assign w_shift = r_state == ST_SHIFT;
  always_comb begin
    w_nxt = (r_state == ST_IDLE)  ? (start ? ((len != '0) ? ST_FILL : ST_DONE) : ST_IDLE) :
            (r_state == ST_FILL)  ? (din_val ? ST_SHIFT : ST_FILL) :
            (r_state == ST_SHIFT) ? ((r_rem == CNT_W'(1)) ? ST_DONE :
                                     (r_bcnt == LAST_BIT) ? ST_FILL : ST_SHIFT) :
            ST_IDLE;
  end
  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_bcnt    <= '0;
      r_din_rdy <= 1'b0;
      r_sc_sen  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_din_rdy <= w_nxt == ST_FILL;
      r_sc_sen  <= w_nxt == ST_SHIFT;
      r_busy    <= w_nxt != ST_IDLE;
      r_done    <= w_nxt == ST_DONE;
      if (r_state == ST_IDLE && start) r_rem <= len;
      else if (w_shift) r_rem <= r_rem - 1'b1;
      if (w_xfer) r_bcnt <= '0;
      else if (w_shift && r_bcnt != LAST_BIT) r_bcnt <= r_bcnt + 1'b1;
    end
  end
  piso_shreg #(.W(WORD_W)) u_shreg (
    .clk(clk),
    .clr(reset),
    .ld (w_xfer),
    .sh (w_shift),
    .d  (din),
    .so (w_sout)
  );
  assign din_rdy  = r_din_rdy;
  assign sc_sen   = r_sc_sen;
  assign dft_sout = r_sc_sen & w_sout;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule

// File: tb/tb_dft_scan_driver.sv
// tb_dft_scan_driver: table-driven scan-load operations checked against a bench-side bit model.
module tb_dft_scan_driver;
  localparam int W = 32;
  localparam int C = 16;
  logic         clk = 1'b0;
  logic         reset, start, din_val;
  logic [C-1:0] len;
  logic [W-1:0] din;
  logic         din_rdy, dft_sout, sc_sen, busy, done;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [C-1:0] len;
    logic [W-1:0] w0, w1, w2;
    int stall_n, start_bit, reset_bit;
    int exp_xfers, exp_sen, exp_dones;
  } vec_t;
  vec_t vecs[8];
  dft_scan_driver #(.WORD_W(W), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .din(din), .din_val(din_val),
    .din_rdy(din_rdy), .dft_sout(dft_sout), .sc_sen(sc_sen), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [W-1:0] wsel(input vec_t t, input int i);
    return (i == 0) ? t.w0 : (i == 1) ? t.w1 : (i == 2) ? t.w2 : 32'hDEAD_BEEF;
  endfunction
  initial begin
    vecs[0] = '{16'd32, 32'hA5A5_0F0F, 32'h0, 32'h0, 0, -1, -1, 1, 32, 1};
    vecs[1] = '{16'd70, 32'h0000_0001, 32'h8000_0000, 32'h0000_0003, 0, -1, -1, 3, 70, 1};
    vecs[2] = '{16'd0, 32'h1, 32'h0, 32'h0, 0, -1, -1, 0, 0, 1};
    vecs[3] = '{16'd40, 32'h1234_5678, 32'h0000_00FF, 32'h0, 10, -1, -1, 2, 40, 1};
    vecs[4] = '{16'd64, 32'hCAFE_F00D, 32'h0F0F_3C3C, 32'h0, 0, 10, -1, 2, 64, 1};
    vecs[5] = '{16'd64, 32'hFFFF_FFFF, 32'h5555_AAAA, 32'h0, 0, -1, 17, 1, 17, 0};
    vecs[6] = '{16'd8, 32'h0000_00C3, 32'h0, 32'h0, 0, -1, -1, 1, 8, 1};
    vecs[7] = '{16'd33, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0, 0, -1, -1, 2, 33, 1};
    reset = 1'b1; start = 1'b0; len = '0; din = '0; din_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({din_rdy, sc_sen, dft_sout, busy, done}), 0);
    reset = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 8; v++) begin
      int xfers, sen, dones, inv, bitidx, widx, stall_left;
      bit prev_sen, prev_xfer, prev_rdy, done_prev, finished;
      xfers = 0; sen = 0; dones = 0; inv = 0; bitidx = 0; widx = 0;
      stall_left = vecs[v].stall_n;
      prev_sen = 0; prev_xfer = 0; prev_rdy = 0; done_prev = 0; finished = 0;
      chk($sformatf("v%0d_idle_busy", v), int'(busy), 0);
      start = 1'b1; len = vecs[v].len; din_val = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        bit s_rdy, s_sen, s_out, s_busy, s_done, xfer;
        s_rdy = din_rdy; s_sen = sc_sen; s_out = dft_sout; s_busy = busy; s_done = done;
        if (done_prev) begin
          chk($sformatf("v%0d_busy_after_done", v), int'(s_busy), 0);
          chk($sformatf("v%0d_done_single", v), int'(s_done), 0);
          finished = 1;
          break;
        end
        if (s_sen) begin
          logic [W-1:0] w;
          w = wsel(vecs[v], bitidx / W);
          chk($sformatf("v%0d_bit%0d", v, bitidx), int'(s_out), int'(w[bitidx % W]));
          bitidx++; sen++;
        end
        if (!s_sen && s_out) inv++;
        if (s_rdy && (s_sen || s_done)) inv++;
        if ((s_rdy || s_sen || s_done) && !s_busy) inv++;
        if (s_sen && !prev_sen && !prev_xfer) inv++;
        if (prev_rdy && !prev_xfer && !s_rdy) inv++;
        if (s_done) begin
          dones++;
          if (vecs[v].len != 0 && !prev_sen) inv++;
          done_prev = 1;
        end
        start = (vecs[v].start_bit >= 0 && s_sen && bitidx == vecs[v].start_bit);
        len = start ? 16'd5 : vecs[v].len;
        din_val = !(widx == 1 && stall_left > 0);
        if (!din_val && s_rdy) stall_left--;
        din = wsel(vecs[v], widx);
        xfer = s_rdy && din_val;
        if (xfer) begin
          xfers++; widx++;
        end
        prev_sen = s_sen; prev_xfer = xfer; prev_rdy = s_rdy;
        if (vecs[v].reset_bit >= 0 && s_sen && bitidx == vecs[v].reset_bit) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0; din_val = 1'b0;
          chk($sformatf("v%0d_reset_outputs", v), int'({din_rdy, sc_sen, dft_sout, busy, done}), 0);
          repeat (3) begin
            @(negedge clk);
            if (done) dones++;
          end
          finished = 1;
          break;
        end
        @(negedge clk);
      end
      start = 1'b0; din_val = 1'b0;
      chk($sformatf("v%0d_finished", v), int'(finished), 1);
      chk($sformatf("v%0d_xfers", v), xfers, vecs[v].exp_xfers);
      chk($sformatf("v%0d_sen_bits", v), sen, vecs[v].exp_sen);
      chk($sformatf("v%0d_dones", v), dones, vecs[v].exp_dones);
      chk($sformatf("v%0d_protocol_violations", v), inv, 0);
      @(negedge clk);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dft_scan_driver.md
DFT_SCAN_DRIVER -- requirements
Module: dft_scan_driver

Interface
REQ-001 Parameter WORD_W, default 32, width of the parallel word input.
REQ-002 Parameter CNT_W, default 16, width of the chain-length field and the remaining-bit counter.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin one scan-load operation; sampled only in IDLE.
REQ-006 len  input  CNT_W  chain length in bits; sampled with start.
REQ-007 din  input  WORD_W  parallel scan-data word; bit 0 is shifted first.
REQ-008 din_val  input  1  din holds a valid word.
REQ-009 din_rdy  output  1  block accepts din this cycle; a transfer occurs when din_val and din_rdy are both high.
REQ-010 dft_sout  output  1  serial scan data to the chain's scan-in.
REQ-011 sc_sen  output  1  scan enable to the chain; high only on cycles carrying a valid bit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse on operation completion.

Function
REQ-014 FSM states: IDLE, FILL, SHIFT, DONE.
REQ-015 IDLE: on start with len != 0, latch len into remaining -> FILL; on start with len == 0 -> DONE; start while not IDLE is ignored.
REQ-016 FILL: din_rdy = 1; sc_sen = 0; on transfer, load din into the shift register, clear bit counter -> SHIFT; with no transfer, hold in FILL indefinitely.
REQ-017 SHIFT: sc_sen = 1; dft_sout = shift register bit 0; every cycle shift right by one, decrement remaining, increment bit counter.
REQ-018 SHIFT exit: remaining == 1 on this cycle -> DONE (takes precedence); else bit counter == WORD_W-1 -> FILL; else stay.
REQ-019 DONE: done = 1 for exactly one cycle, din_rdy = 0, sc_sen = 0 -> IDLE.
REQ-020 din_rdy is 0 in IDLE, SHIFT and DONE; no word is accepted outside FILL.
REQ-021 dft_sout = 0 whenever sc_sen = 0.
REQ-022 Bits are shifted out LSB first, word order as received; exactly len bits are driven with sc_sen = 1 per operation.
REQ-023 Partial last word (len not a multiple of WORD_W): the unshifted upper bits are discarded; no extra word is requested.
REQ-024 Throughput with din_val held high: WORD_W bits per WORD_W+1 cycles (one FILL cycle per word).
REQ-025 Latency: first sc_sen cycle is the cycle after the first din transfer; done asserts the cycle after the last sc_sen cycle.
REQ-026 remaining and bit counter never wrap; len = 2^CNT_W - 1 is the maximum supported length.

Reset
REQ-027 reset forces IDLE, shift register = 0, remaining = 0, bit counter = 0 on the next edge, overriding all other inputs.
REQ-028 Reset values: din_rdy = 0, dft_sout = 0, sc_sen = 0, busy = 0, done = 0.
REQ-029 Reset mid-operation aborts without a done pulse; any word in flight is dropped.

Structure
REQ-030 Package dft_pkg holds the FSM state encoding and the WORD_W and CNT_W defaults, shared with the SIPO capture side.
REQ-031 The shift register is one sub-module, piso_shreg, with load, shift-enable, synchronous clear and serial output.
REQ-032 FSM, remaining-bit counter and bit counter reside in dft_scan_driver; no other sub-modules.

Verification
REQ-033 len = 32, single word 0xA5A5_0F0F -> sc_sen high 32 consecutive cycles, dft_sout = 1,1,1,1,0,0,0,0,... (LSB first), done pulse the following cycle.
REQ-034 len = 70, words 0x0000_0001, 0x8000_0000, 0x0000_0003, din_val always high -> 3 transfers, sc_sen pattern 32/gap/32/gap/6, done after bit 70, fourth word never accepted.
REQ-035 len = 0 with start -> DONE next cycle, done pulses once, din_rdy and sc_sen never assert.
REQ-036 len = 40, din_val withheld 10 cycles in second FILL -> din_rdy stays high, sc_sen = 0 and dft_sout = 0 throughout stall, resume with correct bit 32.
REQ-037 start pulsed during SHIFT of a len = 64 operation -> ignored; exactly 64 bits and one done.
REQ-038 reset asserted at bit 17 of len = 64 -> next cycle IDLE, all outputs 0, no done; a subsequent len = 8 operation completes correctly.
